hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 23 ++
 rtl/sb_reg_counter.sv | 28 ++
 rtl/hazard_scoreboard.sv | 168 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared cpu definitions for the issue hazard scoreboard.
// MDU state encoding, register-file geometry and latency classes.
package hazard_scoreboard_pkg;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    // Cycles from issue until a result can be forwarded.
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MFC0 = 1;

    // Counter width needed to hold latencies 0..max_lat.
    function automatic int lat_width(input int max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Pending-latency counter for one architectural register.
// Latency: load/decrement visible the cycle after the edge; 0 means forwardable.
// Backpressure: hold freezes the count; clear (flush) and rst win over everything.
module sb_reg_counter #(
    parameter int LATW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            hold,
    input  logic            load,
    input  logic [LATW-1:0] load_val,
    output logic [LATW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - LATW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order multi-lane issue scoreboard: register latency tracking plus MDU occupancy.
// Latency: issue_mask is combinational; scoreboard and MDU state update on the next edge.
// Backpressure: pipe_stall/flush suppress issue; lane i issues only if all older lanes do.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int  LANES   = 2,
    parameter int  MAX_LAT = 3,
    parameter int  DIV_LAT = 8,
    localparam int LATW    = lat_width(MAX_LAT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_stall,
    input  logic                   flush,
    input  logic [LANES-1:0]       dec_valid,
    input  logic [LANES*REG_W-1:0] dec_rs,
    input  logic [LANES*REG_W-1:0] dec_rt,
    input  logic [LANES-1:0]       dec_read_rs,
    input  logic [LANES-1:0]       dec_read_rt,
    input  logic [LANES-1:0]       dec_wr,
    input  logic [LANES*REG_W-1:0] dec_rd,
    input  logic [LANES*LATW-1:0]  dec_lat,
    input  logic [LANES-1:0]       dec_mdu,
    input  logic [LANES-1:0]       dec_hilo_read,
    output logic [LANES-1:0]       issue_mask,
    output logic                   stall_D,
    output logic                   mdu_busy
);

    localparam int              MDUW     = $clog2(DIV_LAT);
    localparam logic [MDUW-1:0] MDU_LOAD = MDUW'(DIV_LAT - 1);
    localparam logic [LATW-1:0] LAT_CAP  = LATW'(MAX_LAT);

    logic [LATW-1:0]       reg_cnt  [NUM_REGS];
    logic [NUM_REGS-1:1]   load_en;
    logic [LATW-1:0]       load_val [1:NUM_REGS-1];

    logic                  chain_ok;
    logic                  mdu_seen;
    logic                  lane_ok;
    logic [REG_W-1:0]      rs_i;
    logic [REG_W-1:0]      rt_i;
    logic [REG_W-1:0]      rd_i;
    logic [REG_W-1:0]      rd_j;
    logic [REG_W-1:0]      rd_w;
    logic [LATW-1:0]       lat_w;

    mdu_state_t            state;
    mdu_state_t            state_nxt;
    logic [MDUW-1:0]       mdu_cnt;
    logic [MDUW-1:0]       mdu_cnt_nxt;
    logic                  mdu_start;

    // $0 is hard-wired, so it always reads as ready.
    assign reg_cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        sb_reg_counter #(
            .LATW(LATW)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clear   (flush),
            .hold    (pipe_stall),
            .load    (load_en[r]),
            .load_val(load_val[r]),
            .cnt     (reg_cnt[r])
        );
    end

    // Oldest-first walk: a blocked lane breaks the chain so the mask stays a prefix.
    always_comb begin
        chain_ok   = ~pipe_stall & ~flush;
        mdu_seen   = 1'b0;
        lane_ok    = 1'b0;
        rs_i       = '0;
        rt_i       = '0;
        rd_i       = '0;
        rd_j       = '0;
        issue_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            rs_i    = dec_rs[i*REG_W +: REG_W];
            rt_i    = dec_rt[i*REG_W +: REG_W];
            rd_i    = dec_rd[i*REG_W +: REG_W];
            lane_ok = chain_ok & dec_valid[i];
            if (dec_read_rs[i] && (reg_cnt[rs_i] != '0)) lane_ok = 1'b0;
            if (dec_read_rt[i] && (reg_cnt[rt_i] != '0)) lane_ok = 1'b0;
            for (int j = 0; j < i; j++) begin
                rd_j = dec_rd[j*REG_W +: REG_W];
                if (dec_wr[j] && (rd_j != '0)) begin
                    if (dec_read_rs[i] && (rs_i == rd_j)) lane_ok = 1'b0;
                    if (dec_read_rt[i] && (rt_i == rd_j)) lane_ok = 1'b0;
                    if (dec_wr[i] && (rd_i == rd_j))      lane_ok = 1'b0;
                end
            end
            // HI/LO readers and new MDU ops both wait out any MDU op ahead of them.
            if ((dec_mdu[i] || dec_hilo_read[i]) && (mdu_busy || mdu_seen)) lane_ok = 1'b0;
            mdu_seen      = mdu_seen | dec_mdu[i];
            issue_mask[i] = lane_ok;
            chain_ok      = lane_ok;
        end
    end

    // WAW blocking guarantees at most one issued writer per register.
    always_comb begin
        load_en = '0;
        rd_w    = '0;
        lat_w   = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            load_val[r] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            rd_w  = dec_rd[i*REG_W +: REG_W];
            lat_w = dec_lat[i*LATW +: LATW];
            if (issue_mask[i] && dec_wr[i] && (rd_w != '0)) begin
                load_en[rd_w]  = 1'b1;
                load_val[rd_w] = (lat_w > LAT_CAP) ? LAT_CAP : lat_w;
            end
        end
    end

    assign stall_D   = ~issue_mask[0] & dec_valid[0];
    assign mdu_start = |(issue_mask & dec_mdu);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MDU_IDLE;
            mdu_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mdu_cnt <= mdu_cnt_nxt;
        end
    end

    // The divider runs on its own once started; pipe_stall does not pause it.
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        if (flush) begin
            state_nxt   = MDU_IDLE;
            mdu_cnt_nxt = '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (mdu_start) begin
                        state_nxt   = MDU_BUSY;
                        mdu_cnt_nxt = MDU_LOAD;
                    end
                end
                MDU_BUSY: begin
                    if (mdu_cnt == '0) begin
                        state_nxt = MDU_IDLE;
                    end else begin
                        mdu_cnt_nxt = mdu_cnt - MDUW'(1);
                    end
                end
                default: begin
                    state_nxt   = MDU_IDLE;
                    mdu_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign mdu_busy = (state == MDU_BUSY);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard: 2-lane default instance plus a 4-lane
// instance with MAX_LAT=2 for prefix masks and latency saturation.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;

    // 2-lane instance
    logic        pipe_stall, flush;
    logic [1:0]  dec_valid, dec_read_rs, dec_read_rt, dec_wr, dec_mdu, dec_hilo_read;
    logic [9:0]  dec_rs, dec_rt, dec_rd;
    logic [3:0]  dec_lat;
    logic [1:0]  issue_mask;
    logic        stall_D, mdu_busy;

    // 4-lane instance
    logic        q_pipe_stall, q_flush;
    logic [3:0]  q_dec_valid, q_dec_read_rs, q_dec_read_rt, q_dec_wr, q_dec_mdu, q_dec_hilo_read;
    logic [19:0] q_dec_rs, q_dec_rt, q_dec_rd;
    logic [7:0]  q_dec_lat;
    logic [3:0]  q_issue_mask;
    logic        q_stall_D, q_mdu_busy;

    logic        exp_busy;
    logic [1:0]  exp_mask;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .pipe_stall(pipe_stall), .flush(flush),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_read_rs(dec_read_rs), .dec_read_rt(dec_read_rt),
        .dec_wr(dec_wr), .dec_rd(dec_rd), .dec_lat(dec_lat),
        .dec_mdu(dec_mdu), .dec_hilo_read(dec_hilo_read),
        .issue_mask(issue_mask), .stall_D(stall_D), .mdu_busy(mdu_busy)
    );

    hazard_scoreboard #(.LANES(4), .MAX_LAT(2), .DIV_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .pipe_stall(q_pipe_stall), .flush(q_flush),
        .dec_valid(q_dec_valid), .dec_rs(q_dec_rs), .dec_rt(q_dec_rt),
        .dec_read_rs(q_dec_read_rs), .dec_read_rt(q_dec_read_rt),
        .dec_wr(q_dec_wr), .dec_rd(q_dec_rd), .dec_lat(q_dec_lat),
        .dec_mdu(q_dec_mdu), .dec_hilo_read(q_dec_hilo_read),
        .issue_mask(q_issue_mask), .stall_D(q_stall_D), .mdu_busy(q_mdu_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_valid = '0; dec_rs = '0; dec_rt = '0; dec_read_rs = '0; dec_read_rt = '0;
        dec_wr = '0; dec_rd = '0; dec_lat = '0; dec_mdu = '0; dec_hilo_read = '0;
    endtask

    task automatic clear_dec4();
        q_dec_valid = '0; q_dec_rs = '0; q_dec_rt = '0; q_dec_read_rs = '0; q_dec_read_rt = '0;
        q_dec_wr = '0; q_dec_rd = '0; q_dec_lat = '0; q_dec_mdu = '0; q_dec_hilo_read = '0;
    endtask

    // Arguments: lane, rs, read_rs, rt, read_rt, wr, rd, lat, mdu, hilo_read
    task automatic set_lane(input int l, input int rs, input int rrs, input int rt, input int rrt,
                            input int wr, input int rd, input int lat, input int mdu, input int hilo);
        dec_valid[l]      = 1'b1;
        dec_rs[l*5 +: 5]  = 5'(rs);
        dec_read_rs[l]    = 1'(rrs);
        dec_rt[l*5 +: 5]  = 5'(rt);
        dec_read_rt[l]    = 1'(rrt);
        dec_wr[l]         = 1'(wr);
        dec_rd[l*5 +: 5]  = 5'(rd);
        dec_lat[l*2 +: 2] = 2'(lat);
        dec_mdu[l]        = 1'(mdu);
        dec_hilo_read[l]  = 1'(hilo);
    endtask

    task automatic set_lane4(input int l, input int rs, input int rrs, input int rt, input int rrt,
                             input int wr, input int rd, input int lat, input int mdu, input int hilo);
        q_dec_valid[l]      = 1'b1;
        q_dec_rs[l*5 +: 5]  = 5'(rs);
        q_dec_read_rs[l]    = 1'(rrs);
        q_dec_rt[l*5 +: 5]  = 5'(rt);
        q_dec_read_rt[l]    = 1'(rrt);
        q_dec_wr[l]         = 1'(wr);
        q_dec_rd[l*5 +: 5]  = 5'(rd);
        q_dec_lat[l*2 +: 2] = 2'(lat);
        q_dec_mdu[l]        = 1'(mdu);
        q_dec_hilo_read[l]  = 1'(hilo);
    endtask

    task automatic test_reset();
        rst = 1'b1; pipe_stall = 1'b0; flush = 1'b0; q_pipe_stall = 1'b0; q_flush = 1'b0;
        clear_dec(); clear_dec4();
        tick(); tick();
        rst = 1'b0; #1;
        n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_busy: got %b want 0", mdu_busy); end
        n_checks++; if (q_mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_busy4: got %b want 0", q_mdu_busy); end
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL reset_idle_mask: got %b want 00", issue_mask); end
        n_checks++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL reset_stall_D: got %b want 0", stall_D); end
        set_lane(0, 5, 1, 0, 0, 1, 6, LAT_ALU, 0, 0);
        set_lane(1, 7, 1, 8, 1, 1, 9, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b11) begin n_fail++; $display("FAIL reset_empty_issue: got %b want 11", issue_mask); end
        clear_dec();
    endtask

    task automatic test_load_use();
        set_lane(0, 1, 1, 0, 0, 1, 5, LAT_LOAD, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL lw5_issue: got %b want 01", issue_mask); end
        tick();
        clear_dec();
        set_lane(0, 5, 1, 2, 1, 1, 6, LAT_ALU, 0, 0);
        set_lane(1, 2, 1, 0, 0, 1, 8, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL load_use_c1: got %b want 00", issue_mask); end
        n_checks++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL load_use_stall_D: got %b want 1", stall_D); end
        tick();
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL load_use_c2: got %b want 00", issue_mask); end
        tick();
        n_checks++; if (issue_mask !== 2'b11) begin n_fail++; $display("FAIL load_use_c3: got %b want 11", issue_mask); end
        tick();
        clear_dec();
    endtask

    task automatic test_intra_bundle();
        set_lane(0, 1, 1, 2, 1, 1, 3, LAT_ALU, 0, 0);
        set_lane(1, 3, 1, 0, 0, 1, 4, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL raw_in_bundle: got %b want 01", issue_mask); end
        tick();
        clear_dec();
        set_lane(0, 3, 1, 0, 0, 1, 4, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL raw_next_cycle: got %b want 01", issue_mask); end
        clear_dec();
        set_lane(0, 1, 1, 0, 0, 1, 10, LAT_ALU, 0, 0);
        set_lane(1, 2, 1, 0, 0, 1, 10, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL waw_in_bundle: got %b want 01", issue_mask); end
        clear_dec();
        set_lane(0, 1, 1, 0, 0, 1, 0, LAT_ALU, 0, 0);
        set_lane(1, 0, 1, 0, 0, 1, 0, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b11) begin n_fail++; $display("FAIL r0_no_hazard: got %b want 11", issue_mask); end
        clear_dec();
        set_lane(1, 1, 1, 0, 0, 1, 11, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL prefix_hole: got %b want 00", issue_mask); end
        clear_dec();
    endtask

    task automatic test_mdu();
        set_lane(0, 8, 1, 9, 1, 0, 0, LAT_ALU, 1, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL div_issue: got %b want 01", issue_mask); end
        n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL div_idle_before: got %b want 0", mdu_busy); end
        tick();
        clear_dec();
        set_lane(0, 0, 0, 0, 0, 1, 2, LAT_ALU, 0, 1);
        for (int k = 1; k <= 10; k++) begin
            #1;
            exp_busy = (k <= 8);
            exp_mask = exp_busy ? 2'b00 : 2'b01;
            n_checks++; if (mdu_busy !== exp_busy) begin n_fail++; $display("FAIL div_busy_t%0d: got %b want %b", k, mdu_busy, exp_busy); end
            n_checks++; if (issue_mask !== exp_mask) begin n_fail++; $display("FAIL mfhi_t%0d: got %b want %b", k, issue_mask, exp_mask); end
            tick();
        end
        clear_dec();
        set_lane(0, 8, 1, 9, 1, 0, 0, LAT_ALU, 1, 0);
        set_lane(1, 0, 0, 0, 0, 1, 2, LAT_ALU, 0, 1); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL mult_mflo_bundle: got %b want 01", issue_mask); end
        tick();
        clear_dec(); #1;
        n_checks++; if (mdu_busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy: got %b want 1", mdu_busy); end
    endtask

    task automatic test_flush();
        set_lane(0, 1, 1, 0, 0, 1, 9, 3, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL lw9_issue: got %b want 01", issue_mask); end
        tick();
        clear_dec();
        set_lane(0, 9, 1, 0, 0, 1, 11, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL dep9_blocked: got %b want 00", issue_mask); end
        flush = 1'b1; #1;
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL flush_kills_issue: got %b want 00", issue_mask); end
        tick();
        flush = 1'b0; #1;
        n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL flush_mdu_idle: got %b want 0", mdu_busy); end
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL flush_dep_ready: got %b want 01", issue_mask); end
        clear_dec();
    endtask

    task automatic test_stall();
        set_lane(0, 1, 1, 0, 0, 1, 7, LAT_LOAD, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL lw7_issue: got %b want 01", issue_mask); end
        tick();
        clear_dec();
        set_lane(0, 7, 1, 0, 0, 1, 13, LAT_ALU, 0, 0);
        pipe_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL stall_hold_%0d: got %b want 00", k, issue_mask); end
            tick();
        end
        pipe_stall = 1'b0; #1;
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL stall_rel_c1: got %b want 00", issue_mask); end
        tick();
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL stall_rel_c2: got %b want 00", issue_mask); end
        tick();
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL stall_rel_c3: got %b want 01", issue_mask); end
        clear_dec();
    endtask

    task automatic test_reset_mid();
        set_lane(0, 8, 1, 9, 1, 0, 0, LAT_ALU, 1, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL div2_issue: got %b want 01", issue_mask); end
        tick();
        clear_dec();
        set_lane(0, 1, 1, 0, 0, 1, 12, 3, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL lw12_issue: got %b want 01", issue_mask); end
        tick();
        clear_dec();
        set_lane(0, 12, 1, 0, 0, 1, 14, LAT_ALU, 0, 0); #1;
        n_checks++; if (issue_mask !== 2'b00) begin n_fail++; $display("FAIL dep12_blocked: got %b want 00", issue_mask); end
        n_checks++; if (mdu_busy !== 1'b1) begin n_fail++; $display("FAIL div2_busy: got %b want 1", mdu_busy); end
        rst = 1'b1; pipe_stall = 1'b1;
        tick();
        rst = 1'b0; pipe_stall = 1'b0; #1;
        n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mdu_idle: got %b want 0", mdu_busy); end
        n_checks++; if (issue_mask !== 2'b01) begin n_fail++; $display("FAIL rst_dep_ready: got %b want 01", issue_mask); end
        clear_dec();
    endtask

    task automatic test_lanes4();
        clear_dec4();
        set_lane4(0, 1, 1, 2, 1, 1, 3, LAT_ALU, 0, 0);
        set_lane4(1, 3, 1, 0, 0, 1, 4, LAT_ALU, 0, 0);
        set_lane4(2, 5, 1, 0, 0, 1, 15, LAT_ALU, 0, 0);
        set_lane4(3, 6, 1, 0, 0, 1, 16, LAT_ALU, 0, 0); #1;
        n_checks++; if (q_issue_mask !== 4'b0001) begin n_fail++; $display("FAIL l4_raw_prefix: got %b want 0001", q_issue_mask); end
        tick();
        clear_dec4();
        set_lane4(0, 3, 1, 0, 0, 1, 4, LAT_ALU, 0, 0);
        set_lane4(1, 1, 1, 0, 0, 1, 20, LAT_ALU, 0, 0);
        set_lane4(2, 8, 1, 9, 1, 0, 0, LAT_ALU, 1, 0);
        set_lane4(3, 0, 0, 0, 0, 1, 2, LAT_ALU, 0, 1); #1;
        n_checks++; if (q_issue_mask !== 4'b0111) begin n_fail++; $display("FAIL l4_mult_mflo: got %b want 0111", q_issue_mask); end
        tick();
        clear_dec4();
        set_lane4(0, 1, 1, 0, 0, 1, 5, 3, 0, 0);
        set_lane4(1, 0, 0, 0, 0, 1, 2, LAT_ALU, 0, 1); #1;
        n_checks++; if (q_issue_mask !== 4'b0001) begin n_fail++; $display("FAIL l4_mflo_busy: got %b want 0001", q_issue_mask); end
        n_checks++; if (q_mdu_busy !== 1'b1) begin n_fail++; $display("FAIL l4_mdu_busy: got %b want 1", q_mdu_busy); end
        tick();
        clear_dec4();
        set_lane4(0, 5, 1, 0, 0, 1, 21, LAT_ALU, 0, 0); #1;
        n_checks++; if (q_issue_mask !== 4'b0000) begin n_fail++; $display("FAIL l4_sat_c1: got %b want 0000", q_issue_mask); end
        tick();
        n_checks++; if (q_issue_mask !== 4'b0000) begin n_fail++; $display("FAIL l4_sat_c2: got %b want 0000", q_issue_mask); end
        tick();
        n_checks++; if (q_issue_mask !== 4'b0001) begin n_fail++; $display("FAIL l4_sat_c3: got %b want 0001", q_issue_mask); end
        clear_dec4();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_intra_bundle();
        test_mdu();
        test_flush();
        test_stall();
        test_reset_mid();
        test_lanes4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
